// File: rtl/first_counter_enable_gen.sv
// first_counter_enable_gen
// Programmable enable-strobe generator feeding the enable input of the
// downstream 4-bit up-counter. It divides clk by (div_val + 1) and emits
// one-cycle enable pulses. It runs either continuously (burst_len == 0) or for
// a fixed burst of burst_len pulses. The sequencing logic starts and aborts it
// with start/stop.
//
// Optional build macro: ENABLE_GEN_SYNC_EN
//   When defined, start and stop each pass through a two-flop synchronizer
//   before reaching the FSM. That adds two cycles to every start/stop response.
//   div_val and burst_len are still sampled directly.
//
// Ports:
//   clk        in   single system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   level request to begin generating pulses (ignored unless idle)
//   stop       in   level request to abort; wins over start
//   div_val    in   [DIV_W]   pulse period minus 1, latched on accepted start
//   burst_len  in   [BURST_W] pulses per burst, 0 = continuous, latched on start
//   enable     out  registered one-cycle strobe
//   busy       out  registered, high while running or finishing a burst
//   done       out  registered, high with the last pulse of a finite burst
module first_counter_enable_gen #(
    parameter int DIV_W   = 8,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [DIV_W-1:0]   div_val,
    input  logic [BURST_W-1:0] burst_len,
    output logic               enable,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0]   DIV_ZERO   = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]   DIV_ONE    = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] BURST_ZERO = {BURST_W{1'b0}};
    localparam logic [BURST_W-1:0] BURST_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};

    state_t             state_r, state_s;
    logic [DIV_W-1:0]   pre_cnt_r, pre_cnt_s;
    logic [DIV_W-1:0]   div_q_r, div_q_s;
    logic [BURST_W-1:0] pulse_cnt_r, pulse_cnt_s;
    logic [BURST_W-1:0] burst_q_r, burst_q_s;
    logic               enable_r, enable_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               start_s, stop_s;

`ifdef ENABLE_GEN_SYNC_EN
    logic [1:0] start_sync_r;
    logic [1:0] stop_sync_r;

    // Two-flop synchronizers for the request inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            start_sync_r <= 2'b00;
            stop_sync_r  <= 2'b00;
        end else begin
            start_sync_r <= {start_sync_r[0], start};
            stop_sync_r  <= {stop_sync_r[0], stop};
        end
    end

    assign start_s = start_sync_r[1];
    assign stop_s  = stop_sync_r[1];
`else
    assign start_s = start;
    assign stop_s  = stop;
`endif

    // Next-state, counter and output decode
    always_comb begin
        state_s     = state_r;
        pre_cnt_s   = pre_cnt_r;
        pulse_cnt_s = pulse_cnt_r;
        div_q_s     = div_q_r;
        burst_q_s   = burst_q_r;
        enable_s    = 1'b0;
        busy_s      = busy_r;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // stop wins over a simultaneous start
                if (start_s && !stop_s) begin
                    state_s     = ST_RUN;
                    div_q_s     = div_val;
                    burst_q_s   = burst_len;
                    pre_cnt_s   = DIV_ZERO;
                    pulse_cnt_s = BURST_ZERO;
                    busy_s      = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end
            end
            ST_RUN: begin
                if (stop_s) begin
                    // abort; a pulse due on this edge is suppressed
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else if (pre_cnt_r == div_q_r) begin
                    enable_s    = 1'b1;
                    busy_s      = 1'b1;
                    pre_cnt_s   = DIV_ZERO;
                    pulse_cnt_s = pulse_cnt_r + BURST_ONE;
                    // pulse_cnt_s is the number of the pulse being issued now;
                    // in continuous mode it simply wraps
                    if ((burst_q_r != BURST_ZERO) && (pulse_cnt_s == burst_q_r)) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    busy_s    = 1'b1;
                    pre_cnt_s = pre_cnt_r + DIV_ONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, counters, latched configuration and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            pre_cnt_r   <= DIV_ZERO;
            pulse_cnt_r <= BURST_ZERO;
            div_q_r     <= DIV_ZERO;
            burst_q_r   <= BURST_ZERO;
            enable_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            pre_cnt_r   <= pre_cnt_s;
            pulse_cnt_r <= pulse_cnt_s;
            div_q_r     <= div_q_s;
            burst_q_r   <= burst_q_s;
            enable_r    <= enable_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign enable = enable_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_first_counter_enable_gen.sv
// Self-checking bench for first_counter_enable_gen. The reference model works
// from the elapsed cycles since the accepted start: pulse k falls at k*(d+1).
module tb_first_counter_enable_gen;

`ifdef ENABLE_GEN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] div_val = 8'd0;
    logic [3:0] burst_len = 4'd0;
    logic       enable, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    first_counter_enable_gen #(.DIV_W(8), .BURST_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .div_val(div_val), .burst_len(burst_len),
        .enable(enable), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int   cyc = 0;
    bit   m_run = 1'b0, m_fin = 1'b0;
    int   m_t0 = 0, m_d = 0, m_b = 0;
    logic m_en = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    logic st_h1 = 1'b0, st_h2 = 1'b0, sp_h1 = 1'b0, sp_h2 = 1'b0;

    always @(posedge clk) begin
        logic st_e, sp_e;
        int   el;
        cyc++;
`ifdef ENABLE_GEN_SYNC_EN
        st_e = st_h2;
        sp_e = sp_h2;
        if (reset) begin
            st_h1 = 1'b0; st_h2 = 1'b0; sp_h1 = 1'b0; sp_h2 = 1'b0;
        end else begin
            st_h2 = st_h1; st_h1 = start; sp_h2 = sp_h1; sp_h1 = stop;
        end
`else
        st_e = start;
        sp_e = stop;
`endif
        if (reset || m_fin) begin
            m_run = 1'b0; m_fin = 1'b0;
            m_en = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        end else if (!m_run) begin
            m_en = 1'b0; m_done = 1'b0;
            if (st_e && !sp_e) begin
                m_run = 1'b1; m_t0 = cyc; m_d = int'(div_val); m_b = int'(burst_len);
                m_busy = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end else if (sp_e) begin
            m_run = 1'b0; m_en = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            el = cyc - m_t0;
            m_busy = 1'b1;
            m_done = 1'b0;
            m_en = ((el % (m_d + 1)) == 0);
            if (m_en && (m_b != 0) && ((el / (m_d + 1)) == m_b)) begin
                m_done = 1'b1;
                m_fin  = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({enable, busy, done} !== 3'b000) begin
                n_err++;
                $display("FAIL reset i=%0d got en/busy/done=%b%b%b want 000", i, enable, busy, done);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_continuous();
        logic [3:0] cnt4 = 4'd0;
        int         saw_done = 0;
        div_val = 8'd3; burst_len = 4'd0;
        for (int k = 0; k <= 14; k++) begin
            logic e_en, e_busy;
            start = (k == 0);
            tick();
            start = 1'b0;
            e_en   = (k >= LAT + 4) && (((k - LAT) % 4) == 0);
            e_busy = (k >= LAT);
            if (enable === 1'b1) cnt4 = cnt4 + 4'd1;
            if (done === 1'b1) saw_done++;
            n_cmp++;
            if (enable !== e_en || busy !== e_busy) begin
                n_err++;
                $display("FAIL continuous k=%0d got en=%b busy=%b want en=%b busy=%b", k, enable, busy, e_en, e_busy);
            end
            n_cmp++;
            if (enable !== m_en || busy !== m_busy || done !== m_done) begin
                n_err++;
                $display("FAIL continuous_model k=%0d got %b%b%b want %b%b%b", k, enable, busy, done, m_en, m_busy, m_done);
            end
        end
        n_cmp++;
        if (cnt4 !== 4'd3 || saw_done != 0) begin
            n_err++;
            $display("FAIL continuous_count got cnt=%0d done_seen=%0d want cnt=3 done_seen=0", cnt4, saw_done);
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        div_val = 8'd0; burst_len = 4'd4;
        for (int k = 0; k <= 8 + LAT; k++) begin
            logic e_en, e_busy, e_done;
            start = (k == 0);
            tick();
            start = 1'b0;
            e_en   = (k >= LAT + 1) && (k <= LAT + 4);
            e_done = (k == LAT + 4);
            e_busy = (k >= LAT) && (k <= LAT + 4);
            n_cmp++;
            if (enable !== e_en || busy !== e_busy || done !== e_done) begin
                n_err++;
                $display("FAIL burst k=%0d got %b%b%b want %b%b%b", k, enable, busy, done, e_en, e_busy, e_done);
            end
            n_cmp++;
            if (enable !== m_en || busy !== m_busy || done !== m_done) begin
                n_err++;
                $display("FAIL burst_model k=%0d got %b%b%b want %b%b%b", k, enable, busy, done, m_en, m_busy, m_done);
            end
        end
        go_idle();
    endtask

    task automatic test_stop();
        div_val = 8'd2; burst_len = 4'd0;
        for (int k = 0; k <= 10 + LAT; k++) begin
            logic e_en, e_busy;
            start = (k == 0);
            stop  = (k == 6);
            tick();
            start = 1'b0;
            stop  = 1'b0;
            e_en   = (k == LAT + 3);
            e_busy = (k >= LAT) && (k < LAT + 6);
            n_cmp++;
            if (enable !== e_en || busy !== e_busy || done !== 1'b0) begin
                n_err++;
                $display("FAIL stop k=%0d got %b%b%b want %b%b0", k, enable, busy, done, e_en, e_busy);
            end
            n_cmp++;
            if (enable !== m_en || busy !== m_busy || done !== m_done) begin
                n_err++;
                $display("FAIL stop_model k=%0d got %b%b%b want %b%b%b", k, enable, busy, done, m_en, m_busy, m_done);
            end
        end
        go_idle();
    endtask

    task automatic test_requests();
        // start and stop together: stop wins
        div_val = 8'd0; burst_len = 4'd0;
        for (int k = 0; k <= 6 + LAT; k++) begin
            start = (k <= 2);
            stop  = (k <= 2);
            tick();
            n_cmp++;
            if ({enable, busy, done} !== 3'b000) begin
                n_err++;
                $display("FAIL start_stop k=%0d got %b%b%b want 000", k, enable, busy, done);
            end
        end
        start = 1'b0; stop = 1'b0;
        // start re-asserted while running with a new div_val: ignored
        for (int k = 0; k <= 14; k++) begin
            logic e_en, e_busy;
            start   = (k == 0) || (k >= 3 && k <= 5);
            div_val = (k == 0) ? 8'd1 : 8'd5;
            tick();
            e_en   = (k >= LAT + 2) && (((k - LAT) % 2) == 0);
            e_busy = (k >= LAT);
            n_cmp++;
            if (enable !== e_en || busy !== e_busy || done !== 1'b0) begin
                n_err++;
                $display("FAIL restart_ignored k=%0d got %b%b%b want %b%b0", k, enable, busy, done, e_en, e_busy);
            end
            n_cmp++;
            if (enable !== m_en || busy !== m_busy || done !== m_done) begin
                n_err++;
                $display("FAIL restart_model k=%0d got %b%b%b want %b%b%b", k, enable, busy, done, m_en, m_busy, m_done);
            end
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        div_val = 8'd1; burst_len = 4'd8;
        for (int k = 0; k <= 18 + LAT; k++) begin
            logic e_en, e_busy;
            start = (k == 0);
            reset = (k == LAT + 7);
            tick();
            start = 1'b0;
            reset = 1'b0;
            e_en   = (k >= LAT + 2) && (k < LAT + 7) && (((k - LAT) % 2) == 0);
            e_busy = (k >= LAT) && (k < LAT + 7);
            n_cmp++;
            if (enable !== e_en || busy !== e_busy || done !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid k=%0d got %b%b%b want %b%b0", k, enable, busy, done, e_en, e_busy);
            end
            n_cmp++;
            if (enable !== m_en || busy !== m_busy || done !== m_done) begin
                n_err++;
                $display("FAIL reset_mid_model k=%0d got %b%b%b want %b%b%b", k, enable, busy, done, m_en, m_busy, m_done);
            end
        end
        go_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 149) == 0);
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            div_val   = 8'($urandom_range(0, 5));
            burst_len = 4'($urandom_range(0, 6));
            tick();
            n_cmp++;
            if (enable !== m_en || busy !== m_busy || done !== m_done) begin
                n_err++;
                $display("FAIL random i=%0d got %b%b%b want %b%b%b", i, enable, busy, done, m_en, m_busy, m_done);
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_back_to_back();
        test_stop();
        test_requests();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
